datapath_ctrl: RTL and testbench



---
 rtl/datapath_ctrl_pkg.sv | 49 ++++
 rtl/datapath_ctrl_decode.sv | 79 +++++++
 rtl/datapath_ctrl.sv | 103 ++++++++++
 tb/tb_datapath_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath controller: ALU opcodes,
// instruction field constants and controller FSM states.
package datapath_ctrl_pkg;

    // ALU opcodes, datapath encoding shared with the ALU
    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_ADDI  = 8'h01;
    localparam logic [7:0] OP_ADDU  = 8'h02;
    localparam logic [7:0] OP_ADDUI = 8'h03;
    localparam logic [7:0] OP_ADDC  = 8'h04;
    localparam logic [7:0] OP_SUB   = 8'h08;
    localparam logic [7:0] OP_SUBI  = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0A;
    localparam logic [7:0] OP_CMPI  = 8'h0B;
    localparam logic [7:0] OP_AND   = 8'h0D;
    localparam logic [7:0] OP_OR    = 8'h0E;
    localparam logic [7:0] OP_XOR   = 8'h0F;
    localparam logic [7:0] OP_LSH   = 8'h11;
    localparam logic [7:0] OP_NOP   = 8'h17;

    localparam logic [3:0] MAJ_REG   = 4'h0;
    localparam logic [3:0] MAJ_ADDI  = 4'h5;
    localparam logic [3:0] MAJ_ADDUI = 4'h6;
    localparam logic [3:0] MAJ_SUBI  = 4'h9;
    localparam logic [3:0] MAJ_CMPI  = 4'hB;

    localparam logic [3:0] EXT_IMM  = 4'h0;
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_LSH  = 4'h4;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDU = 4'h6;
    localparam logic [3:0] EXT_ADDC = 4'h7;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// Combinational instruction decoder: instr -> ALU controls plus
// register/flag write intent and an illegal indication.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [7:0]  alu_op,
    output logic        use_imm,
    output logic [15:0] imm,
    output logic        writes_reg,
    output logic        writes_flags,
    output logic        illegal
);

    logic [3:0] major;
    logic [3:0] ext;
    logic       ok;
    logic       arith;
    logic       cmp;

    assign major = instr[15:12];
    assign ext   = instr[7:4];

    always_comb begin
        alu_op  = OP_NOP;
        use_imm = 1'b0;
        imm     = '0;
        ok      = 1'b0;
        arith   = 1'b0;
        cmp     = 1'b0;
        if (major == MAJ_REG) begin
            ok = 1'b1;
            unique case (ext)
                EXT_ADD:  begin alu_op = OP_ADD;  arith = 1'b1; end
                EXT_ADDU: begin alu_op = OP_ADDU; arith = 1'b1; end
                EXT_ADDC: begin alu_op = OP_ADDC; arith = 1'b1; end
                EXT_SUB:  begin alu_op = OP_SUB;  arith = 1'b1; end
                EXT_CMP: begin
                    alu_op = OP_CMP;
                    arith  = 1'b1;
                    cmp    = 1'b1;
                end
                EXT_AND:  alu_op = OP_AND;
                EXT_OR:   alu_op = OP_OR;
                EXT_XOR:  alu_op = OP_XOR;
                EXT_LSH:  alu_op = OP_LSH;
                default:  ok = 1'b0;
            endcase
        end else if (ext == EXT_IMM) begin
            ok      = 1'b1;
            use_imm = 1'b1;
            arith   = 1'b1;
            imm     = sext4(instr[3:0]);
            unique case (major)
                MAJ_ADDI: alu_op = OP_ADDI;
                // ADDUI is the only zero-extending immediate form
                MAJ_ADDUI: begin
                    alu_op = OP_ADDUI;
                    imm    = {12'h000, instr[3:0]};
                end
                MAJ_SUBI: alu_op = OP_SUBI;
                MAJ_CMPI: begin
                    alu_op = OP_CMPI;
                    cmp    = 1'b1;
                end
                default: begin
                    ok      = 1'b0;
                    use_imm = 1'b0;
                    arith   = 1'b0;
                    imm     = '0;
                end
            endcase
        end
        writes_reg   = ok && !cmp;
        writes_flags = ok && arith;
        illegal      = !ok;
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller for the RegBank/ALU datapath (IDLE/DECODE/EXEC/WB).
// Define CTRL_ILLEGAL_TRAP_EN to make illegal instructions trap until reset.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  sel_a,
    output logic [3:0]  sel_b,
    output logic [7:0]  alu_op,
    output logic [15:0] imm,
    output logic        use_imm,
    output logic        flag_en,
    output logic [15:0] reg_en,
    output logic        busy,
    output logic        illegal,
    output logic [15:0] retired
);

    state_t      state;
    logic        trap;
    logic        wr_q;
    logic        fl_q;
    logic        ill_q;

    logic [7:0]  d_alu_op;
    logic        d_use_imm;
    logic [15:0] d_imm;
    logic        d_wr;
    logic        d_fl;
    logic        d_ill;

    datapath_ctrl_decode u_decode (
        .instr        (instr),
        .alu_op       (d_alu_op),
        .use_imm      (d_use_imm),
        .imm          (d_imm),
        .writes_reg   (d_wr),
        .writes_flags (d_fl),
        .illegal      (d_ill)
    );

    assign instr_ready = (state == S_IDLE) && !trap;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            trap    <= 1'b0;
            wr_q    <= 1'b0;
            fl_q    <= 1'b0;
            ill_q   <= 1'b0;
            sel_a   <= '0;
            sel_b   <= '0;
            alu_op  <= OP_NOP;
            imm     <= '0;
            use_imm <= 1'b0;
            flag_en <= 1'b0;
            reg_en  <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            flag_en <= 1'b0;
            illegal <= 1'b0;
            reg_en  <= '0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid && !trap) begin
                        sel_a   <= instr[11:8];
                        sel_b   <= instr[3:0];
                        alu_op  <= d_alu_op;
                        imm     <= d_imm;
                        use_imm <= d_use_imm;
                        wr_q    <= d_wr;
                        fl_q    <= d_fl;
                        ill_q   <= d_ill;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    flag_en <= fl_q;
                    illegal <= ill_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    if (ill_q) trap <= 1'b1;
`endif
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_q) reg_en <= 16'h0001 << sel_a;
                    state <= S_WB;
                end
                S_WB: begin
                    if (!ill_q) retired <= retired + 16'h0001;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: vector table with a
// scoreboard queue plus hand-written back-to-back and reset sequences.
module tb_datapath_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [7:0]  alu_op;
    logic [15:0] imm;
    logic        use_imm;
    logic        flag_en;
    logic [15:0] reg_en;
    logic        busy;
    logic        illegal;
    logic [15:0] retired;

    datapath_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .alu_op      (alu_op),
        .imm         (imm),
        .use_imm     (use_imm),
        .flag_en     (flag_en),
        .reg_en      (reg_en),
        .busy        (busy),
        .illegal     (illegal),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [7:0]  op;
        logic [15:0] imm;
        logic        ui;
        logic        fe;
        logic [15:0] re;
        logic        ill;
    } vec_t;

    vec_t        vecs[12];
    vec_t        sb_q[$];
    int          tests;
    int          fails;
    logic [15:0] exp_ret;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, instr_ready}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 16'h0000;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        wait_ready();
        instr = v.instr;
        instr_valid = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        e = sb_q.pop_front();
        chk("sel_a", {28'b0, sel_a}, {28'b0, e.sa});
        chk("sel_b", {28'b0, sel_b}, {28'b0, e.sb});
        chk("alu_op", {24'b0, alu_op}, {24'b0, e.op});
        chk("imm", {16'b0, imm}, {16'b0, e.imm});
        chk("use_imm", {31'b0, use_imm}, {31'b0, e.ui});
        chk("dec_busy_rdy", {30'b0, busy, instr_ready}, 32'd2);
        chk("dec_flag_en", {31'b0, flag_en}, 32'd0);
        @(negedge clk);
        chk("ex_flag_en", {31'b0, flag_en}, {31'b0, e.fe});
        chk("ex_illegal", {31'b0, illegal}, {31'b0, e.ill});
        chk("ex_reg_en", {16'b0, reg_en}, 32'd0);
        @(negedge clk);
        chk("wb_reg_en", {16'b0, reg_en}, {16'b0, e.re});
        chk("wb_pulses", {30'b0, flag_en, illegal}, 32'd0);
        if (!e.ill) exp_ret = exp_ret + 16'h0001;
        @(negedge clk);
        chk("retired", {16'b0, retired}, {16'b0, exp_ret});
        chk("idle_reg_en", {16'b0, reg_en}, 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (e.ill) begin
            repeat (3) begin
                chk("trap_ready", {31'b0, instr_ready}, 32'd0);
                @(negedge clk);
            end
            do_reset();
        end
`endif
        chk("idle_ready", {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_ret = 16'h0000;
        instr = 16'h0000;
        instr_valid = 1'b0;
        reset = 1'b1;

        vecs[0]  = '{16'h0355, 4'h3, 4'h5, 8'h00, 16'h0000, 1'b0, 1'b1, 16'h0008, 1'b0};
        vecs[1]  = '{16'h520D, 4'h2, 4'hD, 8'h01, 16'hFFFD, 1'b1, 1'b1, 16'h0004, 1'b0};
        vecs[2]  = '{16'h620D, 4'h2, 4'hD, 8'h03, 16'h000D, 1'b1, 1'b1, 16'h0004, 1'b0};
        vecs[3]  = '{16'h01B4, 4'h1, 4'h4, 8'h0A, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0A13, 4'hA, 4'h3, 8'h0D, 16'h0000, 1'b0, 1'b0, 16'h0400, 1'b0};
        vecs[5]  = '{16'h0E47, 4'hE, 4'h7, 8'h11, 16'h0000, 1'b0, 1'b0, 16'h4000, 1'b0};
        vecs[6]  = '{16'hB702, 4'h7, 4'h2, 8'h0B, 16'h0002, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{16'h9F0F, 4'hF, 4'hF, 8'h09, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0};
        vecs[8]  = '{16'h0090, 4'h0, 4'h0, 8'h08, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[9]  = '{16'h0C76, 4'hC, 4'h6, 8'h04, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0};
        vecs[10] = '{16'h0581, 4'h5, 4'h1, 8'h17, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[11] = '{16'hF000, 4'h0, 4'h0, 8'h17, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1};

        #1;
        chk("rst_reg_en", {16'b0, reg_en}, 32'd0);
        chk("rst_alu_op", {24'b0, alu_op}, 32'h17);
        chk("rst_sel", {24'b0, sel_a, sel_b}, 32'd0);
        chk("rst_imm", {15'b0, imm, use_imm}, 32'd0);
        chk("rst_pulses", {29'b0, flag_en, illegal, busy}, 32'd0);
        chk("rst_retired", {16'b0, retired}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, instr_ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // illegal 0x5310: immediate major with nonzero ext
        run_vec('{16'h5310, 4'h3, 4'h0, 8'h17, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1});
        run_vec(vecs[0]);

        // back-to-back with instr_valid held high
        wait_ready();
        instr = 16'h0355;
        instr_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) instr = 16'h01B4;
            chk("b2b_not_ready", {31'b0, instr_ready}, 32'd0);
        end
        @(negedge clk);
        chk("b2b_ready4", {31'b0, instr_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_second", {20'b0, sel_a, alu_op}, {20'b0, 4'h1, 8'h0A});
        exp_ret = exp_ret + 16'h0002;
        repeat (3) @(negedge clk);
        chk("b2b_retired", {16'b0, retired}, {16'b0, exp_ret});

        // reset while in EXEC: nothing may complete
        wait_ready();
        instr = 16'h0355;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_outputs", {8'b0, flag_en, reg_en, busy, alu_op},
            {8'b0, 1'b0, 16'h0000, 1'b0, 8'h17});
        chk("arst_retired", {16'b0, retired}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 16'h0000;
        repeat (4) begin
            @(negedge clk);
            chk("arst_quiet", {15'b0, flag_en, reg_en}, 32'd0);
        end
        chk("arst_ready", {31'b0, instr_ready}, 32'd1);
        chk("arst_ret0", {16'b0, retired}, 32'd0);

        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
